coin_acceptor: RTL and testbench

Fare-collection front end that drives the turnstile's coin input. It accumulates coin credit toward a fixed fare and issues a single-cycle coin pulse to the turnstile once the fare is met. It then monitors the turnstile's locked status to count passages, and returns change or cancelled credit. It sits between the coin mechanism and the turnstile FSM, making it the initiator side of the turnstile's coin/locked interface.

---
 rtl/turnstile_pkg.sv | 28 ++
 rtl/timeout_timer.sv | 23 ++
 rtl/coin_acceptor.sv | 109 ++++++++++
 tb/tb_coin_acceptor.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/turnstile_pkg.sv
// turnstile_pkg: states, coin codes and lock levels shared by the coin acceptor and the turnstile
package turnstile_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_VEND,
    S_WAIT_UNLOCK,
    S_WAIT_PASS,
    S_REFUND
  } state_e;

  localparam logic [1:0] COIN_5    = 2'b00;
  localparam logic [1:0] COIN_10   = 2'b01;
  localparam logic [1:0] COIN_25   = 2'b10;
  localparam logic [1:0] COIN_SLUG = 2'b11;

  localparam logic LOCKED   = 1'b1;
  localparam logic UNLOCKED = 1'b0;

  // A slug is worth nothing; callers reject it separately
  function automatic logic [4:0] coin_cents(input logic [1:0] code);
    return code == COIN_5  ? 5'd5  :
           code == COIN_10 ? 5'd10 :
           code == COIN_25 ? 5'd25 : 5'd0;
  endfunction

endpackage

// File: rtl/timeout_timer.sv
// timeout_timer: counts enabled cycles from 0 and flags the TIMEOUT-th one
module timeout_timer #(
  parameter int TIMEOUT = 1000
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] count_q;

  assign expired_o = enable_i && count_q == W'(TIMEOUT - 1);

  always_ff @(posedge i_Clk or posedge i_Reset)
    if (i_Reset) count_q <= '0;
    else if (clear_i) count_q <= '0;
    else if (enable_i && !expired_o) count_q <= count_q + W'(1);

endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor: accumulates coin credit toward FARE, pulses the turnstile coin input,
// counts passages and returns change or cancelled credit
module coin_acceptor
  import turnstile_pkg::*;
#(
  parameter int FARE     = 25,
  parameter int CREDIT_W = 8,
  parameter int TIMEOUT  = 1000
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
  input  logic                i_Coin_Valid,
  input  logic [1:0]          i_Coin_Value,
  input  logic                i_Cancel,
  input  logic                i_Locked,
  output logic                o_Coin,
  output logic [CREDIT_W-1:0] o_Credit,
  output logic                o_Reject,
  output logic                o_Refund_Valid,
  output logic [CREDIT_W-1:0] o_Refund_Amount,
  output logic                o_Fault,
  output logic                o_Busy,
  output logic [15:0]         o_Pass_Count
);

  localparam logic [CREDIT_W-1:0] FARE_C = CREDIT_W'(FARE);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d, sum;
  logic [15:0]         pass_q, pass_d;
  logic                reject_q, reject_d, fault_q, fault_d;
  logic                coin_ok, expired;

  timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .i_Clk    (i_Clk),
    .i_Reset  (i_Reset),
    .clear_i  (state_q != S_WAIT_UNLOCK),
    .enable_i (state_q == S_WAIT_UNLOCK),
    .expired_o(expired)
  );

  always_comb begin
    coin_ok  = i_Coin_Valid && i_Coin_Value != COIN_SLUG &&
               (state_q == S_IDLE || state_q == S_COLLECT);
    sum      = credit_q + CREDIT_W'(coin_cents(i_Coin_Value));
    state_d  = state_q;
    credit_d = credit_q;
    pass_d   = pass_q;
    reject_d = i_Coin_Valid && !coin_ok;
    fault_d  = 1'b0;
    case (state_q)
      S_IDLE: if (coin_ok) begin
        credit_d = sum;
        state_d  = sum >= FARE_C ? S_VEND : S_COLLECT;
      end
      S_COLLECT: begin
        credit_d = coin_ok ? sum : credit_q;
        // cancel wins over reaching the fare; a coincident coin is refunded too
        state_d  = i_Cancel ? S_REFUND :
                   coin_ok  ? (sum >= FARE_C ? S_VEND : S_COLLECT) : S_COLLECT;
      end
      S_VEND: begin
        credit_d = credit_q - FARE_C;
        state_d  = S_WAIT_UNLOCK;
      end
      S_WAIT_UNLOCK:
        if (i_Locked == UNLOCKED) state_d = S_WAIT_PASS;
        else if (expired) begin
          fault_d  = 1'b1;
          credit_d = credit_q + FARE_C;
          state_d  = S_REFUND;
        end
      S_WAIT_PASS: if (i_Locked == LOCKED) begin
        pass_d  = pass_q + 16'd1;
        state_d = credit_q != '0 ? S_REFUND : S_IDLE;
      end
      S_REFUND: begin
        credit_d = '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Reset)
    if (i_Reset) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      pass_q   <= '0;
      reject_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      pass_q   <= pass_d;
      reject_q <= reject_d;
      fault_q  <= fault_d;
    end

  assign o_Coin          = state_q == S_VEND;
  assign o_Credit        = credit_q;
  assign o_Reject        = reject_q;
  assign o_Refund_Valid  = state_q == S_REFUND;
  assign o_Refund_Amount = state_q == S_REFUND ? credit_q : '0;
  assign o_Fault         = fault_q;
  assign o_Busy          = state_q != S_IDLE;
  assign o_Pass_Count    = pass_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: directed scenarios plus random traffic checked against a transaction-level model
module tb_coin_acceptor;

  localparam int FARE = 25;
  localparam int CW   = 8;
  localparam int TO   = 8;

  logic          i_Clk = 1'b0, i_Reset = 1'b1;
  logic          i_Coin_Valid = 1'b0, i_Cancel = 1'b0, i_Locked = 1'b1;
  logic [1:0]    i_Coin_Value = 2'b00;
  logic          o_Coin, o_Reject, o_Refund_Valid, o_Fault, o_Busy;
  logic [CW-1:0] o_Credit, o_Refund_Amount;
  logic [15:0]   o_Pass_Count;

  always #5 i_Clk = ~i_Clk;

  coin_acceptor #(.FARE(FARE), .CREDIT_W(CW), .TIMEOUT(TO)) dut (
    .i_Clk          (i_Clk),
    .i_Reset        (i_Reset),
    .i_Coin_Valid   (i_Coin_Valid),
    .i_Coin_Value   (i_Coin_Value),
    .i_Cancel       (i_Cancel),
    .i_Locked       (i_Locked),
    .o_Coin         (o_Coin),
    .o_Credit       (o_Credit),
    .o_Reject       (o_Reject),
    .o_Refund_Valid (o_Refund_Valid),
    .o_Refund_Amount(o_Refund_Amount),
    .o_Fault        (o_Fault),
    .o_Busy         (o_Busy),
    .o_Pass_Count   (o_Pass_Count)
  );

  int n_cmp = 0, n_bad = 0;
  // transaction-level model: credit, pass count, and what the acceptor is busy doing
  int cr, pc, t;
  bit vend, paid, riding, refunding, fault, rej;
  int cents_tab[4] = '{5, 10, 25, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    cr = 0; pc = 0; t = 0;
    vend = 0; paid = 0; riding = 0; refunding = 0; fault = 0; rej = 0;
  endtask

  task automatic model_step(input bit cv, input int v, input bit c, input bit l);
    bit accepting = !(vend || paid || riding || refunding);
    bit ok = cv && v != 3 && accepting;
    rej   = cv && !ok;
    fault = 0;
    if (refunding) begin
      cr = 0; refunding = 0;
    end else if (vend) begin
      cr -= FARE; vend = 0; paid = 1; t = 0;
    end else if (paid) begin
      if (!l) begin
        paid = 0; riding = 1;
      end else if (t == TO - 1) begin
        fault = 1; cr += FARE; paid = 0; refunding = 1;
      end else t++;
    end else if (riding) begin
      if (l) begin
        pc = (pc + 1) & 16'hFFFF; riding = 0; refunding = cr > 0;
      end
    end else begin
      int old = cr;
      if (ok) cr += cents_tab[v];
      if (c && old > 0) refunding = 1;
      else if (cr >= FARE) vend = 1;
    end
  endtask

  task automatic check_all();
    chk("coin",       32'(o_Coin),          32'(vend));
    chk("credit",     32'(o_Credit),        32'(cr));
    chk("reject",     32'(o_Reject),        32'(rej));
    chk("refund_v",   32'(o_Refund_Valid),  32'(refunding));
    chk("refund_amt", 32'(o_Refund_Amount), refunding ? 32'(cr) : 32'd0);
    chk("fault",      32'(o_Fault),         32'(fault));
    chk("busy",       32'(o_Busy),          32'(vend || paid || riding || refunding || cr != 0));
    chk("pass",       32'(o_Pass_Count),    32'(pc));
  endtask

  task automatic step(input bit cv, input int v, input bit c, input bit l);
    i_Coin_Valid = cv;
    i_Coin_Value = 2'(v);
    i_Cancel     = c;
    i_Locked     = l;
    @(posedge i_Clk);
    model_step(cv, v, c, l);
    #1 check_all();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_coin"},   32'(o_Coin), 0);
    chk({tag, "_credit"}, 32'(o_Credit), 0);
    chk({tag, "_refund"}, 32'(o_Refund_Valid), 0);
    chk({tag, "_busy"},   32'(o_Busy), 0);
    chk({tag, "_pass"},   32'(o_Pass_Count), 0);
  endtask

  initial begin
    model_reset();
    #12 check_zero("rst");
    @(negedge i_Clk) i_Reset = 1'b0;
    @(posedge i_Clk); #1;

    // exact fare
    step(1, 2, 0, 1); chk("exact_coin", 32'(o_Coin), 1); chk("exact_cr", 32'(o_Credit), 25);
    step(0, 0, 0, 1); chk("exact_cr0", 32'(o_Credit), 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0); chk("busy_rej", 32'(o_Reject), 1); chk("busy_rej_cr", 32'(o_Credit), 0);
    step(0, 0, 0, 1); chk("exact_pass", 32'(o_Pass_Count), 1); chk("exact_norefund", 32'(o_Refund_Valid), 0);
    step(0, 0, 0, 1); chk("exact_idle", 32'(o_Busy), 0);

    // overpay
    step(1, 1, 0, 1); step(1, 1, 0, 1); step(1, 1, 0, 1);
    chk("over_coin", 32'(o_Coin), 1);
    step(0, 0, 0, 1); chk("over_cr", 32'(o_Credit), 5);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1); chk("over_refund", 32'(o_Refund_Amount), 5);
    step(0, 0, 0, 1);

    // cancel with coincident coin
    step(1, 1, 0, 1);
    step(1, 0, 1, 1); chk("cancel_amt", 32'(o_Refund_Amount), 15); chk("cancel_nocoin", 32'(o_Coin), 0);
    step(0, 0, 0, 1); chk("cancel_pass", 32'(o_Pass_Count), 2);

    // slug in COLLECT
    step(1, 1, 0, 1);
    step(1, 3, 0, 1); chk("slug_rej", 32'(o_Reject), 1); chk("slug_cr", 32'(o_Credit), 10);
    step(0, 0, 1, 1); step(0, 0, 0, 1);

    // unlock timeout
    step(1, 2, 0, 1); step(0, 0, 0, 1);
    for (int i = 0; i < TO - 1; i++) step(0, 0, 0, 1);
    chk("to_early", 32'(o_Fault), 0);
    step(0, 0, 0, 1); chk("to_fault", 32'(o_Fault), 1); chk("to_amt", 32'(o_Refund_Amount), 25);
    step(0, 0, 0, 1); chk("to_idle", 32'(o_Busy), 0);

    // reset in WAIT_UNLOCK with credit 5
    step(1, 1, 0, 1); step(1, 1, 0, 1); step(1, 1, 0, 1); step(0, 0, 0, 1);
    chk("pre_rst_cr", 32'(o_Credit), 5);
    #2 i_Reset = 1'b1;
    #1 check_zero("midrst");
    model_reset();
    @(negedge i_Clk) i_Reset = 1'b0;
    @(posedge i_Clk); #1;

    // pass count wrap
    @(negedge i_Clk) force dut.pass_q = 16'hFFFF;
    @(negedge i_Clk) release dut.pass_q;
    pc = 16'hFFFF;
    @(posedge i_Clk); #1;
    step(1, 2, 0, 1); step(0, 0, 0, 1); step(0, 0, 0, 0);
    step(0, 0, 0, 1); chk("wrap", 32'(o_Pass_Count), 0);

    // random traffic under varying turnstile behaviour
    for (int b = 0; b < 15; b++) begin
      int bias = $urandom_range(0, 9);
      for (int i = 0; i < 200; i++)
        step($urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 7) == 0,
             $urandom_range(0, 9) < bias);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
